// File: rtl/load_store_unit_if.sv
// Core request/response and byte-lane RAM port bundle for load_store_unit.
// Handshakes: a request transfers on a clk_en edge with i_req_valid & o_req_ready; a response with o_rsp_valid & i_rsp_ready.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_store;
  logic [2:0]            i_req_funct3;
  logic [31:0]           i_req_addr;
  logic [31:0]           i_req_wdata;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;

  logic                  o_ram_read_req;
  logic [ADDR_WIDTH:0]   o_ram_read_addr;
  logic [DATA_WIDTH:0]   i_ram_read_data;
  logic                  o_ram_write_enable;
  logic [3:0]            o_ram_byte_enable;
  logic [ADDR_WIDTH:0]   o_ram_write_addr;
  logic [DATA_WIDTH:0]   o_ram_write_data;

  modport slave (
    input  i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
    output o_req_ready,
    output o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  i_rsp_ready,
    output o_ram_read_req, o_ram_read_addr,
    input  i_ram_read_data,
    output o_ram_write_enable, o_ram_byte_enable, o_ram_write_addr, o_ram_write_data
  );

  modport master (
    output i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output i_rsp_ready,
    input  o_ram_read_req, o_ram_read_addr,
    output i_ram_read_data,
    input  o_ram_write_enable, o_ram_byte_enable, o_ram_write_addr, o_ram_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a byte-lane RAM with one-cycle registered reads.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned/illegal requests get an error response instead of being coerced.
module load_store_unit #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  load_store_unit_if.slave     bus,
  output logic [1:0]           dbg_state
);
  localparam int AW1 = ADDR_WIDTH + 1;

  // Debug encoding: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic                r_store;
  logic [2:0]          r_funct3;
  logic [1:0]          r_lane;
  logic                req_ready;
  logic                rsp_valid;
  logic                rsp_err;
  logic [31:0]         rsp_rdata;
  logic                ram_read_req;
  logic                ram_write_enable;
  logic [3:0]          ram_be;
  logic [ADDR_WIDTH:0] ram_addr;
  logic [31:0]         ram_wdata;

  logic                illegal;
  logic                is_half;
  logic                is_word;
  logic                req_err;
  logic [2:0]          eff_f3;
  logic [31:0]         eff_addr;
  logic [3:0]          req_be;
  logic [31:0]         req_wdata;
  logic [ADDR_WIDTH:0] req_word_addr;

  // Request decode; without the check, illegal funct3 falls back to word and low address bits are dropped.
  always_comb begin
    illegal = bus.i_req_store ? (bus.i_req_funct3 > 3'd2)
                              : ((bus.i_req_funct3 == 3'd3) || (bus.i_req_funct3[2:1] == 2'b11));
    eff_f3   = illegal ? 3'b010 : bus.i_req_funct3;
    is_half  = (eff_f3[1:0] == 2'b01);
    is_word  = (eff_f3[1:0] == 2'b10);
    eff_addr = bus.i_req_addr;
`ifdef LSU_ALIGN_CHECK_EN
    req_err = illegal || (is_half && bus.i_req_addr[0]) ||
              (is_word && (bus.i_req_addr[1:0] != 2'b00));
`else
    req_err = 1'b0;
    if (is_word) begin
      eff_addr[1:0] = 2'b00;
    end else if (is_half) begin
      eff_addr[0] = 1'b0;
    end
`endif
    case (eff_f3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << eff_addr[1:0];
        req_wdata = {4{bus.i_req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{bus.i_req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = bus.i_req_wdata;
      end
    endcase
    req_word_addr = AW1'(eff_addr >> 2);
  end

  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    rd_word = bus.i_ram_read_data;
    case (r_lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = r_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (r_funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      r_store          <= 1'b0;
      r_funct3         <= 3'd0;
      r_lane           <= 2'd0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_rdata        <= 32'd0;
      ram_read_req     <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_be           <= 4'd0;
      ram_addr         <= '0;
      ram_wdata        <= 32'd0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            r_store   <= bus.i_req_store;
            r_funct3  <= eff_f3;
            r_lane    <= eff_addr[1:0];
            ram_addr  <= req_word_addr;
            ram_be    <= req_be;
            ram_wdata <= req_wdata;
            rsp_rdata <= 32'd0;
            rsp_err   <= req_err;
            req_ready <= 1'b0;
            if (req_err) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              ram_write_enable <= bus.i_req_store;
              ram_read_req     <= !bus.i_req_store;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ram_read_req     <= 1'b0;
          ram_write_enable <= 1'b0;
          if (r_store) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Read data is valid exactly here because the RAM froze along with us.
          rsp_rdata <= ld_val;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        default: begin
          if (bus.i_rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_req_ready        = req_ready;
  assign bus.o_rsp_valid        = rsp_valid;
  assign bus.o_rsp_rdata        = rsp_rdata;
  assign bus.o_rsp_err          = rsp_err;
  assign bus.o_ram_read_req     = ram_read_req;
  assign bus.o_ram_read_addr    = ram_addr;
  assign bus.o_ram_write_enable = ram_write_enable;
  assign bus.o_ram_byte_enable  = ram_be;
  assign bus.o_ram_write_addr   = ram_addr;
  assign bus.o_ram_write_data   = ram_wdata;
  assign dbg_state              = state;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the RV32I core's execute stage and the byte-lane `ram` block. It accepts one memory request at a time from the core and turns funct3 plus the byte address into a word address, a 4-bit byte enable and lane-replicated write data. It also accounts for the RAM's one-enabled-cycle read latency. On loads it extracts and sign- or zero-extends the addressed byte or halfword and returns a single response to the core.

## Interface
- `ADDR_WIDTH`, 31: MSB index of the RAM word-address ports (`[ADDR_WIDTH:0]`), matching `ram`.
- `DATA_WIDTH`, 31: MSB index of data ports; only 31 is supported.
- `clk`  in  1  clock; all state on posedge.
- `rst`  in  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
- `clk_en`  in  1  global clock enable; all state holds while 0.
- `i_req_valid`  in  1  core request valid.
- `o_req_ready`  out  1  high only in IDLE.
- `i_req_store`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RV32I load/store funct3.
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data (low bits used for SB/SH).
- `o_rsp_valid`  out  1  response valid; held until accepted.
- `i_rsp_ready`  in  1  core accepts response.
- `o_rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `o_rsp_err`  out  1  misaligned or illegal funct3 (see Configuration).
- `o_ram_read_req`, `o_ram_read_addr[ADDR_WIDTH:0]`  out  RAM read port.
- `i_ram_read_data`  in  `[DATA_WIDTH:0]`  RAM registered read data.
- `o_ram_write_enable`, `o_ram_byte_enable[3:0]`, `o_ram_write_addr[ADDR_WIDTH:0]`, `o_ram_write_data[DATA_WIDTH:0]`  out  RAM write port.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Transitions only on `clk_en`=1 cycles.
- IDLE: on `i_req_valid`, register store, funct3, addr and wdata.
  - Go to ISSUE, or to RESP with `o_rsp_err`=1 if the check fails.
- ISSUE: drive the RAM for exactly this state.
  - Load: `o_ram_read_req`=1, then go to WAIT.
  - Store: `o_ram_write_enable`=1, then go to RESP.
- WAIT: `i_ram_read_data` is valid. Latch the extended result into `o_rsp_rdata`, then go to RESP.
- RESP: `o_rsp_valid`=1. On `i_rsp_ready`, go to IDLE.
- Word address: `addr[ADDR_WIDTH+2:2]` zero-extended/truncated to ADDR_WIDTH+1 bits; drives both read and write address.
- Store funct3 encodings:
  - SB (000): be = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - SH (001): be = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - SW (010): be = 4'b1111; data = wdata.
- Load funct3 encodings; lane is selected by addr[1:0] for bytes and addr[1] for halves:
  - LB 000: sign-extend byte.
  - LH 001: sign-extend half.
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
- Illegal funct3: load 011/110/111; store 011–111.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- RAM strobes are 0 outside ISSUE. Addresses, be and data are don't-care outside ISSUE but are held from the request registers.

## Timing
- Reset values (`rst`=0, async):
  - state IDLE.
  - `o_req_ready`=1.
  - `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0.
  - All RAM strobes 0, be=0, addresses and data 0.
- Load latency with `clk_en` held 1: accept edge → ISSUE (1) → WAIT (2) → RESP. `o_rsp_valid` rises 3 cycles after the accept edge.
- Store latency: `o_rsp_valid` rises 2 cycles after the accept edge.
- Error latency: `o_rsp_valid` rises 1 cycle after the accept edge.
- `clk_en`=0 in any state: freeze state and outputs. The RAM is likewise frozen, so WAIT data stays valid.
- `o_req_ready` depends only on state (registered), never on `i_req_valid`.
- A request presented while not IDLE is ignored; the core must hold it.
- Back-to-back: the accept in IDLE may occur on the cycle right after the RESP handshake.
- `rst` asserted mid-transaction:
  - Abort immediately.
  - A store caught in ISSUE may or may not have been written; this is not guaranteed.
  - No response is produced after reset.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misaligned and illegal-funct3 requests skip the RAM and respond with `o_rsp_err`=1 and rdata 0.
- Undefined:
  - `o_rsp_err` is tied 0.
  - Low address bits are forced to alignment: half ignores addr[0], word ignores addr[1:0].
  - Illegal funct3 is treated as LW/SW.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10.
  - Store: be=1111, write addr=4.
  - Load: rdata=0xDEADBEEF, `o_rsp_valid` 3 cycles after accept.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13.
  - be=1000, write data=0x80808080.
  - LB → 0xFFFFFF80; LBU → 0x00000080.
- SH 0x8001 @0x22, then LH and LHU @0x22.
  - be=1100.
  - LH → 0xFFFF8001; LHU → 0x00008001.
- `clk_en` low for 5 cycles during WAIT with RAM data 0x12345678.
  - No state change while low; rdata=0x12345678 afterwards.
  - `i_rsp_ready` held low for 3 cycles keeps `o_rsp_valid`=1 and data stable.
- With `LSU_ALIGN_CHECK_EN`, LW @0x02.
  - Error response 1 cycle after accept, `o_rsp_err`=1, no RAM strobe.
  - Without the macro: reads word addr 0, no error.
- Assert `rst` in ISSUE of a load.
  - All outputs go to reset values asynchronously.
  - No `o_rsp_valid` follows.
  - The next request completes normally.
